// File: rtl/mmio_pkg.sv
// Address-map helpers and STATUS bit layout for the J17 MMIO data memory.
package mmio_pkg;

  localparam int IN_VALID_BIT = 0;

  function automatic int sw_ofs(input int n_disp);
    return n_disp;
  endfunction

  function automatic int stat_ofs(input int n_disp);
    return n_disp + 1;
  endfunction

  function automatic int ram_base(input int n_disp);
    return n_disp + 2;
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser for asynchronous board inputs, with an optional
// rising-edge pulse taken from the synchronised value.
module input_sync #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2;

  // metastability chain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  if (EDGE) begin : g_edge
    logic [W-1:0] s3;
    // previous synchronised value for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) s3 <= '0;
      else          s3 <= s2;
    end
    assign rise = s2 & ~s3;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

// File: rtl/mmio_data_mem.sv
// Data RAM plus MMIO window (displays, switches, input-ready flag) on the
// J17 data port. One-cycle request/ack, full throughput.
module mmio_data_mem
  import mmio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 64,
  parameter int N_DISP = 3,
  parameter int IN_W   = 18,
  parameter int SEG_W  = 7
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ack,
  output logic                    err,
  input  logic [IN_W-1:0]         sw,
  input  logic                    bin,
  output logic [N_DISP*SEG_W-1:0] disp
);

  localparam int SW_A   = sw_ofs(N_DISP);
  localparam int ST_A   = stat_ofs(N_DISP);
  localparam int RB     = ram_base(N_DISP);
  localparam int RAM_N  = DEPTH - RB;
  localparam int RAM_AW = (RAM_N > 1) ? $clog2(RAM_N) : 1;

  logic [IN_W-1:0]               sw_s;
  logic [IN_W-1:0]               unused_sw_rise;
  logic                          unused_bin_q;
  logic                          bin_rise;
  logic [N_DISP-1:0][DATA_W-1:0] disp_reg;
  logic [DATA_W-1:0]             mem [RAM_N];
  logic                          in_valid;

  logic [31:0]       a32;
  logic              is_sw, is_stat, is_ram, is_ill, bad;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] rd_val;

  input_sync #(.W(IN_W), .EDGE(1'b0)) u_sw_sync (
    .clock(clock), .reset_n(reset_n), .d(sw), .q(sw_s), .rise(unused_sw_rise)
  );

  input_sync #(.W(1), .EDGE(1'b1)) u_bin_sync (
    .clock(clock), .reset_n(reset_n), .d(bin), .q(unused_bin_q), .rise(bin_rise)
  );

  // address decode and read-data mux
  always_comb begin
    a32     = 32'(addr);
    is_sw   = (a32 == 32'(SW_A));
    is_stat = (a32 == 32'(ST_A));
    is_ram  = (a32 >= 32'(RB)) && (a32 < 32'(DEPTH));
    is_ill  = (a32 >= 32'(DEPTH));
    ram_idx = RAM_AW'(a32 - 32'(RB));
    bad     = is_ill | (write & (is_sw | is_stat));
    rd_val  = '0;
    for (int k = 0; k < N_DISP; k++)
      if (a32 == 32'(k)) rd_val = disp_reg[k];
    if (is_sw)   rd_val = DATA_W'(sw_s);
    if (is_stat) rd_val[IN_VALID_BIT] = in_valid;
    if (is_ram)  rd_val = mem[ram_idx];
  end

  // display registers keep the full word; only low SEG_W bits reach the pins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_reg <= '0;
    end else begin
      for (int k = 0; k < N_DISP; k++)
        if (req && write && a32 == 32'(k)) disp_reg[k] <= wdata;
    end
  end

  for (genvar k = 0; k < N_DISP; k++) begin : g_disp
    assign disp[k*SEG_W +: SEG_W] = disp_reg[k][SEG_W-1:0];
  end

  // RAM array, deliberately without reset
  always_ff @(posedge clock) begin
    if (req && write && is_ram) mem[ram_idx] <= wdata;
  end

  // sticky input-ready flag: button edge sets, SW read clears, set wins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    in_valid <= 1'b0;
    else if (bin_rise)               in_valid <= 1'b1;
    else if (req && !write && is_sw) in_valid <= 1'b0;
  end

  // response register: ack/err pulse for one cycle, rdata holds until next read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= req;
      err <= req & bad;
      if (req && !write) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_data_mem.sv
// Directed bench for mmio_data_mem with a cycle-level reference model.
module tb_mmio_data_mem;

  localparam int SWA = 3;
  localparam int STA = 4;

  logic        clock, reset_n;
  logic        req, write;
  logic [9:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack, err;
  logic [17:0] sw;
  logic        bin;
  logic [20:0] disp;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_data_mem #(
    .DATA_W(32), .ADDR_W(10), .DEPTH(64), .N_DISP(3), .IN_W(18), .SEG_W(7)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .sw(sw), .bin(bin),
    .disp(disp)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_disp [3];
  logic [31:0] m_mem  [64];
  bit          m_wr   [64];
  logic [17:0] sh1, sh2;          // sw sampled 1 and 2 edges ago
  bit          bh1, bh2, bh3;     // bin sampled 1, 2, 3 edges ago
  bit          m_flag;
  bit          e_ack, e_err, e_known;
  logic [31:0] e_rdata;
  bit          edge_now;
  int          a;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) m_disp[k] = '0;
      sh1 = '0; sh2 = '0; bh1 = 0; bh2 = 0; bh3 = 0;
      m_flag = 0; e_ack = 0; e_err = 0; e_rdata = '0; e_known = 1;
    end else begin
      edge_now = bh2 && !bh3;
      e_ack = req;
      e_err = 0;
      if (req) begin
        a = int'(addr);
        if (a >= 64) begin
          e_err = 1;
          if (!write) begin e_rdata = '0; e_known = 1; end
        end else if (write) begin
          if (a < 3)                  m_disp[a] = wdata;
          else if (a == SWA || a == STA) e_err = 1;
          else begin m_mem[a] = wdata; m_wr[a] = 1; end
        end else begin
          e_known = 1;
          if (a < 3)         e_rdata = m_disp[a];
          else if (a == SWA) e_rdata = {14'b0, sh2};
          else if (a == STA) e_rdata = {31'b0, m_flag};
          else begin e_rdata = m_mem[a]; e_known = m_wr[a]; end
        end
      end
      if (edge_now) m_flag = 1;
      else if (req && !write && addr == 10'(SWA)) m_flag = 0;
      sh2 = sh1; sh1 = sw;
      bh3 = bh2; bh2 = bh1; bh1 = bin;
    end
  end

  // per-cycle comparison against the model
  logic [20:0] e_disp;
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) e_disp[k*7 +: 7] = m_disp[k][6:0];
    cmp("ack", 32'(ack), 32'(e_ack));
    cmp("err", 32'(err), 32'(e_err));
    if (e_known) cmp("rdata", rdata, e_rdata);
    cmp("disp", 32'(disp), 32'(e_disp));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit w, input int ad, input logic [31:0] d);
    req = 1; write = w; addr = 10'(ad); wdata = d;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    req = 0; write = 0;
    @(posedge clock); #1;
  endtask

  initial begin
    req = 0; write = 0; addr = 0; wdata = 0; sw = 0; bin = 0; reset_n = 0;
    repeat (4) begin
      @(posedge clock); #1;
      req = 1'($urandom); write = 1'($urandom); addr = 10'($urandom);
      wdata = $urandom; sw = 18'($urandom); bin = 1'($urandom);
    end
    cmp("rst_disp", 32'(disp), 32'h0);
    cmp("rst_ack", 32'(ack), 32'h0);
    cmp("rst_rdata", rdata, 32'h0);
    req = 0; write = 0; sw = 0; bin = 0;
    @(posedge clock); #1;
    reset_n = 1;
    idle();

    // STATUS after reset
    drive(0, STA, 0);
    cmp("stat_rst", rdata, 32'h0);
    idle();

    // displays
    drive(1, 1, 32'h0000007F);
    cmp("disp1_seg", 32'(disp[13:7]), 32'h7F);
    drive(0, 1, 0);
    cmp("disp1_rd", rdata, 32'h7F);
    cmp("disp1_ack", 32'(ack), 32'h1);
    drive(1, 0, 32'h12345601);
    drive(1, 2, 32'hFFFFFF80);
    drive(0, 2, 0);
    cmp("disp2_full", rdata, 32'hFFFFFF80);
    idle();

    // switches
    sw = 18'h2A5A5;
    idle(); idle();
    drive(0, SWA, 0);
    cmp("sw_rd", rdata, 32'h0002A5A5);
    cmp("sw_err", 32'(err), 32'h0);
    idle();

    // flag set, then cleared by SW read
    bin = 1;
    idle(); idle(); idle();
    drive(0, STA, 0);
    cmp("flag_set", rdata, 32'h1);
    bin = 0;
    drive(0, SWA, 0);
    drive(0, STA, 0);
    cmp("flag_clr", rdata, 32'h0);
    idle(); idle(); idle();
    // edge coincident with SW read: set wins
    bin = 1;
    idle(); idle();
    drive(0, SWA, 0);
    drive(0, STA, 0);
    cmp("flag_win", rdata, 32'h1);
    bin = 0;
    idle();

    // RAM, including first and last words
    drive(1, 10, 32'hDEADBEEF);
    drive(0, 10, 0);
    cmp("ram10", rdata, 32'hDEADBEEF);
    drive(1, 5, 32'hA5A50005);
    drive(1, 63, 32'h0BADF00D);
    drive(0, 5, 0);
    drive(0, 63, 0);
    cmp("ram63", rdata, 32'h0BADF00D);
    drive(0, 10, 0);
    drive(0, 5, 0);
    cmp("ram5", rdata, 32'hA5A50005);
    idle();

    // illegal accesses
    drive(1, 64, 32'h55);
    cmp("ill_wr_err", 32'(err), 32'h1);
    drive(1, STA, 32'hFFFFFFFF);
    cmp("stat_wr_err", 32'(err), 32'h1);
    drive(1, SWA, 32'h1);
    drive(0, 64, 0);
    cmp("ill_rd_data", rdata, 32'h0);
    cmp("ill_rd_err", 32'(err), 32'h1);
    drive(0, 1023, 0);
    drive(0, 1, 0);
    cmp("disp1_kept", rdata, 32'h7F);
    idle();

    // reset in the middle of a response
    drive(1, 20, 32'hCAFEF00D);
    drive(0, 1, 0);
    reset_n = 0;
    #1;
    cmp("midrst_ack", 32'(ack), 32'h0);
    @(posedge clock); #1;
    reset_n = 1;
    idle();
    drive(0, 20, 0);
    cmp("ram_after_rst", rdata, 32'hCAFEF00D);
    drive(0, 1, 0);
    cmp("disp_after_rst", rdata, 32'h0);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
